apb_timer_nch: RTL and testbench

- APB slave containing NCH independent timer channels, each with its own counter.
- Each channel has a prescaler, compare/auto-reload, a one-shot mode and a sticky match flag.
- Flags are write-1-to-clear; a masked, OR-reduced IRQ goes to the system interrupt controller.
- Sits on the APB subsystem alongside the other peripherals.

---
 rtl/apb_timer_pkg.sv | 33 +++
 rtl/apb_timer_ch.sv | 93 +++++++++
 rtl/apb_timer_nch.sv | 138 +++++++++++++
 tb/tb_apb_timer_nch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Purpose: shared register map, CTRL bit positions and helpers for the APB multi-channel timer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package apb_timer_pkg;

  // Per-channel register block: channel c lives at c * CH_STRIDE
  localparam logic [11:0] CH_STRIDE = 12'h020;
  localparam logic [4:0]  OFF_TMR   = 5'h00;
  localparam logic [4:0]  OFF_PRE   = 5'h04;
  localparam logic [4:0]  OFF_CMP   = 5'h08;
  localparam logic [4:0]  OFF_CTRL  = 5'h0C;

  // Global registers, above the channel region
  localparam logic [11:0] ADDR_STATUS = 12'h100;
  localparam logic [11:0] ADDR_IRQEN  = 12'h104;
  localparam logic [11:0] ADDR_ICR    = 12'h108;
  localparam logic [11:0] ADDR_EVCNT  = 12'h10C;

  // CTRL register bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;

  // Value returned for any address with no register behind it
  localparam logic [31:0] UNMAPPED_RD = 32'hDEADBEEF;

  // Add a small event count to a 32-bit counter, sticking at all-ones
  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [3:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {29'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/apb_timer_ch.sv
// Purpose: one timer channel - prescaler, up-counter with compare/auto-reload, one-shot, match pulse.
// Latency: match is combinational in the tick cycle; evt is the registered copy one cycle later.
// Backpressure: none; register writes always accepted and take effect at the write edge.
module apb_timer_ch
  import apb_timer_pkg::*;
#(
  parameter int CW = 32,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_tmr,
  input  logic          wr_pre,
  input  logic          wr_cmp,
  input  logic          wr_ctrl,
  input  logic [31:0]   wdata,
  output logic [CW-1:0] tmr,
  output logic [PW-1:0] pre,
  output logic [CW-1:0] cmp,
  output logic [1:0]    ctrl,
  output logic          match,
  output logic          evt
);

  logic [PW-1:0] pcnt;
  logic          en;
  logic          oneshot;
  logic          tick;
  logic          en_rise;
  logic          unused_wdata;

  // Only the low CW/PW bits of the bus are stored; fold the rest away
  assign unused_wdata = ^wdata;

  assign tick    = en & (pcnt == pre);
  assign en_rise = wr_ctrl & ~en & wdata[CTRL_EN];
  // A TMR write in the tick cycle overrides the count, so no match is taken
  assign match   = tick & (tmr == cmp) & ~wr_tmr;
  assign ctrl    = {oneshot, en};

  // Prescaler: counts 0..PRE while enabled, restarts on tick, TMR write or enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (wr_tmr || en_rise || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Main counter: software load wins, enable edge clears, otherwise step or reload on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (wr_tmr) begin
      tmr <= wdata[CW-1:0];
    end else if (en_rise) begin
      tmr <= '0;
    end else if (tick) begin
      tmr <= match ? '0 : tmr + CW'(1);
    end
  end

  // Configuration registers; a CTRL write beats the one-shot auto-disable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      cmp     <= '0;
      en      <= 1'b0;
      oneshot <= 1'b0;
    end else begin
      if (wr_pre) pre <= wdata[PW-1:0];
      if (wr_cmp) cmp <= wdata[CW-1:0];
      if (wr_ctrl) begin
        en      <= wdata[CTRL_EN];
        oneshot <= wdata[CTRL_ONESHOT];
      end else if (match && oneshot) begin
        en <= 1'b0;
      end
    end
  end

  // Registered one-cycle event pulse following each match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt <= 1'b0;
    end else begin
      evt <= match;
    end
  end

endmodule

// File: rtl/apb_timer_nch.sv
// Purpose: APB slave wrapping NCH timer channels with sticky flags, IRQ masking and an event counter.
// Latency: zero-wait-state APB; PRDATA combinational from PADDR; IRQ follows the registered flags.
// Backpressure: none; PREADY is tied high.
module apb_timer_nch
  import apb_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PW  = 16
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           PSEL,
  input  logic [11:2]    PADDR,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           IRQ,
  output logic [NCH-1:0] CH_EVT
);

  localparam logic [11:0] CH_SPAN = CH_STRIDE * 12'(NCH);

  logic [11:0]    byte_addr;
  logic           wr_en;
  logic           in_ch;
  logic [2:0]     ch_sel;
  logic [4:0]     ch_off;
  logic           wr_irqen;
  logic           wr_icr;

  logic [CW-1:0]  tmr_rd  [NCH];
  logic [PW-1:0]  pre_rd  [NCH];
  logic [CW-1:0]  cmp_rd  [NCH];
  logic [1:0]     ctrl_rd [NCH];
  logic [NCH-1:0] match_vec;

  logic [NCH-1:0] status;
  logic [NCH-1:0] irqen;
  logic [NCH-1:0] icr_mask;
  logic [31:0]    evcnt;
  logic [3:0]     nmatch;
  logic [31:0]    rdata;

  assign byte_addr = {PADDR, 2'b00};
  assign wr_en     = PSEL & PWRITE & PENABLE;
  assign in_ch     = (byte_addr < CH_SPAN);
  assign ch_sel    = byte_addr[7:5];
  assign ch_off    = byte_addr[4:0];
  assign wr_irqen  = wr_en & (byte_addr == ADDR_IRQEN);
  assign wr_icr    = wr_en & (byte_addr == ADDR_ICR);
  assign icr_mask  = wr_icr ? PWDATA[NCH-1:0] : '0;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en & in_ch & (ch_sel == 3'(c));

    apb_timer_ch #(
      .CW(CW),
      .PW(PW)
    ) u_ch (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .wr_tmr  (ch_wr & (ch_off == OFF_TMR)),
      .wr_pre  (ch_wr & (ch_off == OFF_PRE)),
      .wr_cmp  (ch_wr & (ch_off == OFF_CMP)),
      .wr_ctrl (ch_wr & (ch_off == OFF_CTRL)),
      .wdata   (PWDATA),
      .tmr     (tmr_rd[c]),
      .pre     (pre_rd[c]),
      .cmp     (cmp_rd[c]),
      .ctrl    (ctrl_rd[c]),
      .match   (match_vec[c]),
      .evt     (CH_EVT[c])
    );
  end

  // Number of channels matching this cycle, for the event counter
  always_comb begin
    nmatch = '0;
    for (int c = 0; c < NCH; c++) begin
      nmatch = nmatch + 4'(match_vec[c]);
    end
  end

  // Sticky flags: a new match beats a same-cycle write-1-to-clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      status <= '0;
    end else begin
      status <= (status & ~icr_mask) | match_vec;
    end
  end

  // Interrupt mask and saturating event count
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irqen <= '0;
      evcnt <= '0;
    end else begin
      if (wr_irqen) irqen <= PWDATA[NCH-1:0];
      evcnt <= sat_add32(evcnt, nmatch);
    end
  end

  // Read mux, driven purely by the address
  always_comb begin
    rdata = UNMAPPED_RD;
    if (in_ch) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (ch_off)
            OFF_TMR:  rdata = 32'(tmr_rd[c]);
            OFF_PRE:  rdata = 32'(pre_rd[c]);
            OFF_CMP:  rdata = 32'(cmp_rd[c]);
            OFF_CTRL: rdata = 32'(ctrl_rd[c]);
            default:  rdata = UNMAPPED_RD;
          endcase
        end
      end
    end else begin
      case (byte_addr)
        ADDR_STATUS: rdata = 32'(status);
        ADDR_IRQEN:  rdata = 32'(irqen);
        ADDR_ICR:    rdata = 32'h0;
        ADDR_EVCNT:  rdata = evcnt;
        default:     rdata = UNMAPPED_RD;
      endcase
    end
  end

  assign PRDATA = rdata;
  assign PREADY = 1'b1;
  assign IRQ    = |(status & irqen);

endmodule

// File: tb/tb_apb_timer_nch.sv
// Purpose: self-checking bench for apb_timer_nch (NCH=4, CW=8 so counter wrap is reachable).
// Latency: register effects checked one edge after each write; events tracked per cycle.
// Backpressure: bench ignores PREADY for timing but checks that it stays high.
module tb_apb_timer_nch;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 16;

  logic           PCLK    = 1'b0;
  logic           PRESETn = 1'b0;
  logic           PSEL    = 1'b0;
  logic           PENABLE = 1'b0;
  logic           PWRITE  = 1'b0;
  logic [11:2]    PADDR   = '0;
  logic [31:0]    PWDATA  = '0;
  logic [31:0]    PRDATA;
  logic           PREADY;
  logic           IRQ;
  logic [NCH-1:0] CH_EVT;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int ch;
    int cyc;
  } ev_t;

  ev_t         evq [$];
  ev_t         mon_e;
  logic [31:0] rdq [$];

  apb_timer_nch #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PADDR   (PADDR),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .IRQ     (IRQ),
    .CH_EVT  (CH_EVT)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after an edge E; the write lands at edge E+2
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a[11:2]; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a[11:2];
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_edge(input int target);
    if (cyc > target) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_edge: at cycle %0d, required cycle <= %0d", cyc, target);
    end
    while (cyc < target) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic push_ev(input int ch, input int c);
    ev_t e;
    e.ch  = ch;
    e.cyc = c;
    evq.push_back(e);
  endtask

  // Every CH_EVT pulse must match the next expected (channel, cycle) entry
  always @(negedge PCLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (CH_EVT[c] === 1'b1) begin
        if (evq.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL ch_evt: unexpected pulse on ch%0d at cycle %0d, required none", c, cyc);
        end else begin
          mon_e = evq.pop_front();
          check($sformatf("ch_evt_ch@%0d", cyc), 32'(c), 32'(mon_e.ch));
          check($sformatf("ch_evt_cycle_ch%0d", c), 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    vec_t        tbl [24];
    logic [31:0] d;
    logic [31:0] e;
    int          seq [5];
    int          w0, e1, e2, e3, e4, e5;

    // ---- reset state ----
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_ch_evt", 32'(CH_EVT), 32'd0);
    check("rst_pready", 32'(PREADY), 32'd1);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // ---- register map table: {addr, write, wdata, expected readback} ----
    tbl[0]  = '{12'h000, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{12'h004, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{12'h008, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{12'h00C, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{12'h060, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{12'h100, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{12'h104, 1'b0, 32'h0, 32'h0};
    tbl[7]  = '{12'h108, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{12'h10C, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{12'h010, 1'b0, 32'h0, 32'hDEADBEEF};
    tbl[10] = '{12'h1F0, 1'b0, 32'h0, 32'hDEADBEEF};
    tbl[11] = '{12'h080, 1'b0, 32'h0, 32'hDEADBEEF};
    tbl[12] = '{12'h03C, 1'b0, 32'h0, 32'hDEADBEEF};
    tbl[13] = '{12'h110, 1'b0, 32'h0, 32'hDEADBEEF};
    tbl[14] = '{12'h024, 1'b1, 32'h0001_2345, 32'h0000_2345};
    tbl[15] = '{12'h028, 1'b1, 32'h0000_01FF, 32'h0000_00FF};
    tbl[16] = '{12'h020, 1'b1, 32'h0000_0033, 32'h0000_0033};
    tbl[17] = '{12'h02C, 1'b1, 32'hFFFF_FFFE, 32'h0000_0002};
    tbl[18] = '{12'h104, 1'b1, 32'hFFFF_FFFF, 32'h0000_000F};
    tbl[19] = '{12'h108, 1'b1, 32'h0000_000F, 32'h0};
    tbl[20] = '{12'h10C, 1'b1, 32'h0000_0005, 32'h0};
    tbl[21] = '{12'h100, 1'b1, 32'h0000_000F, 32'h0};
    tbl[22] = '{12'h010, 1'b1, 32'h0000_1234, 32'hDEADBEEF};
    tbl[23] = '{12'h104, 1'b1, 32'h0000_0000, 32'h0};

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].we) apb_wr(tbl[i].addr, tbl[i].wdata);
      rdq.push_back(tbl[i].exp);
      apb_rd(tbl[i].addr, d);
      e = rdq.pop_front();
      check($sformatf("map_vec%0d_addr%03h", i, tbl[i].addr), d, e);
      check($sformatf("pready_vec%0d", i), 32'(PREADY), 32'd1);
      @(posedge PCLK); #1;
    end

    // ---- ch0 free-running, PRE=0 CMP=4: period 5 ----
    apb_wr(12'h004, 32'd0);
    apb_wr(12'h008, 32'd4);
    apb_wr(12'h104, 32'd1);
    apb_wr(12'h00C, 32'd1);
    w0 = cyc;
    push_ev(0, w0 + 5);
    push_ev(0, w0 + 10);
    push_ev(0, w0 + 15);
    seq = '{1, 2, 3, 4, 0};
    for (int k = 1; k <= 5; k++) begin
      @(posedge PCLK); #1;
      chk_rd($sformatf("ch0_tmr_step%0d", k), 12'h000, 32'(seq[k-1]));
      check($sformatf("ch0_irq_step%0d", k), 32'(IRQ), 32'(k == 5));
      chk_rd($sformatf("ch0_status_step%0d", k), 12'h100, 32'(k == 5));
    end
    apb_wr(12'h108, 32'd1);                      // lands w0+7
    check("icr_clears_irq", 32'(IRQ), 32'd0);
    chk_rd("icr_clears_status", 12'h100, 32'd0);
    wait_edge(w0 + 13);
    apb_wr(12'h108, 32'd1);                      // lands on the w0+15 match edge
    chk_rd("icr_vs_set_status", 12'h100, 32'd1);
    check("icr_vs_set_irq", 32'(IRQ), 32'd1);
    apb_wr(12'h00C, 32'd0);                      // lands w0+17, last tick at that edge
    repeat (3) @(posedge PCLK);
    #1;
    chk_rd("ch0_frozen_tmr", 12'h000, 32'd2);
    chk_rd("evcnt_after_ch0", 12'h10C, 32'd3);
    apb_wr(12'h108, 32'd1);
    chk_rd("status_clear_ch0", 12'h100, 32'd0);

    // ---- TMR write on the cycle that would otherwise match ----
    apb_wr(12'h00C, 32'd1);
    e1 = cyc;
    wait_edge(e1 + 3);
    apb_wr(12'h000, 32'd7);                      // lands e1+5 where TMR==CMP would match
    chk_rd("tmr_write_wins", 12'h000, 32'd7);
    apb_wr(12'h00C, 32'd0);                      // lands e1+7
    chk_rd("tmr_after_write_run", 12'h000, 32'd9);
    repeat (3) @(posedge PCLK);
    #1;
    chk_rd("tmr_after_write_frozen", 12'h000, 32'd9);
    chk_rd("tmr_write_no_flag", 12'h100, 32'd0);
    chk_rd("tmr_write_no_evcnt", 12'h10C, 32'd3);

    // ---- ch1 one-shot, PRE=2 CMP=1: single match 6 cycles after enable ----
    apb_wr(12'h024, 32'd2);
    apb_wr(12'h028, 32'd1);
    apb_wr(12'h02C, 32'd3);
    e2 = cyc;
    push_ev(1, e2 + 6);
    wait_edge(e2 + 3);
    chk_rd("os_tmr_first_tick", 12'h020, 32'd1);
    wait_edge(e2 + 5);
    chk_rd("os_ctrl_running", 12'h02C, 32'd3);
    chk_rd("os_status_before", 12'h100, 32'd0);
    wait_edge(e2 + 6);
    chk_rd("os_ctrl_disabled", 12'h02C, 32'd2);
    chk_rd("os_tmr_reload", 12'h020, 32'd0);
    chk_rd("os_status_set", 12'h100, 32'd2);
    check("os_irq_masked", 32'(IRQ), 32'd0);
    wait_edge(e2 + 15);
    chk_rd("os_tmr_holds", 12'h020, 32'd0);
    chk_rd("os_evcnt", 12'h10C, 32'd4);
    apb_wr(12'h104, 32'd3);
    check("irqen_unmask_irq", 32'(IRQ), 32'd1);
    apb_wr(12'h108, 32'd2);
    check("icr_bit1_irq", 32'(IRQ), 32'd0);

    // ---- CTRL write EN=1 on the one-shot auto-disable edge: write wins ----
    apb_wr(12'h02C, 32'd3);
    e3 = cyc;
    push_ev(1, e3 + 6);
    push_ev(1, e3 + 12);
    wait_edge(e3 + 4);
    apb_wr(12'h02C, 32'd3);                      // lands e3+6, the match edge
    chk_rd("os_vs_ctrl_en_kept", 12'h02C, 32'd3);
    wait_edge(e3 + 9);
    chk_rd("os_vs_ctrl_tmr", 12'h020, 32'd1);
    wait_edge(e3 + 12);
    chk_rd("os_vs_ctrl_second_stop", 12'h02C, 32'd2);
    chk_rd("os_evcnt2", 12'h10C, 32'd6);
    apb_wr(12'h108, 32'd2);

    // ---- ch2: CMP lowered below TMR, must wrap through 255 ----
    apb_wr(12'h044, 32'd0);
    apb_wr(12'h048, 32'd200);
    apb_wr(12'h04C, 32'd1);
    e4 = cyc;
    wait_edge(e4 + 9);
    apb_wr(12'h048, 32'd5);                      // lands e4+11, TMR was 10 in that cycle
    chk_rd("wrap_tmr_at_write", 12'h040, 32'd11);
    push_ev(2, e4 + 262);
    wait_edge(e4 + 256);
    chk_rd("wrap_tmr_zero", 12'h040, 32'd0);
    chk_rd("wrap_no_flag_at_zero", 12'h100, 32'd0);
    wait_edge(e4 + 261);
    chk_rd("wrap_tmr_at_cmp", 12'h040, 32'd5);
    chk_rd("wrap_no_flag_yet", 12'h100, 32'd0);
    wait_edge(e4 + 262);
    chk_rd("wrap_tmr_reload", 12'h040, 32'd0);
    chk_rd("wrap_flag", 12'h100, 32'd4);
    apb_wr(12'h04C, 32'd0);
    chk_rd("wrap_evcnt", 12'h10C, 32'd7);
    apb_wr(12'h108, 32'd4);

    // ---- asynchronous reset in the middle of counting ----
    apb_wr(12'h068, 32'd100);
    apb_wr(12'h06C, 32'd1);                      // ch3 starts, lands e5-2
    apb_wr(12'h00C, 32'd1);                      // ch0 starts
    e5 = cyc;
    wait_edge(e5 + 5);                           // ch0 match edge; no pulse is queued
    check("pre_rst_ch_evt", 32'(CH_EVT), 32'd1);
    check("pre_rst_irq", 32'(IRQ), 32'd1);
    chk_rd("pre_rst_tmr3", 12'h060, 32'd7);
    PRESETn = 1'b0;
    #1;
    check("async_rst_irq", 32'(IRQ), 32'd0);
    check("async_rst_ch_evt", 32'(CH_EVT), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      chk_rd($sformatf("async_rst_tmr%0d", c), 12'(c * 32), 32'd0);
    end
    repeat (2) @(posedge PCLK);
    #1;
    chk_rd("rst_status", 12'h100, 32'd0);
    chk_rd("rst_evcnt", 12'h10C, 32'd0);
    chk_rd("rst_ctrl0", 12'h00C, 32'd0);
    chk_rd("rst_unmapped", 12'h010, 32'hDEADBEEF);
    PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk_rd("post_rst_tmr0_idle", 12'h000, 32'd0);

    check("events_all_seen", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
